// File: rtl/mult_div_unit_pkg.sv
// Shared CPU package: multiply/divide op codes, FSM states, iteration count.
// Also carries the magnitude helper used when latching signed operands.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam logic [5:0] ITER_CNT = 6'd32;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_addsub.sv
// muldiv_addsub: 33-bit adder/subtractor for one multiply or divide iteration.
// Combinational; on subtract, cout=1 means no borrow (a >= b).
// No flow control: pure function of its inputs.
module muldiv_addsub (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] sum,
    output logic        cout
);

    logic [33:0] full;

    assign full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {33'd0, sub};
    assign sum  = full[32:0];
    assign cout = full[33];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide, signed and unsigned, one bit per cycle.
// Latency: Done is high in the cycle after the 34th edge following the Start edge.
// Start is accepted only while Ready (IDLE or DONE); Start while Busy is dropped.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] OperandA,
    input  logic [31:0] OperandB,
    output logic        Ready,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        DivByZero
);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic [31:0] b_q, b_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dbz_q, dbz_d;

    logic [32:0] as_a, as_b, as_sum;
    logic        as_sub, as_cout;
    logic        accept, signed_op, a_neg, b_neg;
    logic [63:0] prod, prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign Ready     = (state_q == IDLE) || (state_q == DONE);
    assign Busy      = (state_q == CALC) || (state_q == FIX);
    assign Done      = (state_q == DONE);
    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign DivByZero = dbz_q;

    assign accept    = Start && Ready;
    assign signed_op = (Op == OP_MULT) || (Op == OP_DIV);
    assign a_neg     = signed_op && OperandA[31];
    assign b_neg     = signed_op && OperandB[31];

    // Divide: shift the next dividend bit into the partial remainder, trial-subtract.
    // Multiply: add the multiplicand when the current multiplier bit is set.
    always_comb begin
        if (is_div_q) begin
            as_a   = {acc_hi_q, acc_lo_q[31]};
            as_b   = {1'b0, b_q};
            as_sub = 1'b1;
        end else begin
            as_a   = {1'b0, acc_hi_q};
            as_b   = acc_lo_q[0] ? {1'b0, b_q} : 33'd0;
            as_sub = 1'b0;
        end
    end

    muldiv_addsub u_addsub (
        .a    (as_a),
        .b    (as_b),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (as_cout)
    );

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_lo_q ? (~prod + 64'd1) : prod;
    assign quo_fix  = neg_lo_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
    assign rem_fix  = neg_hi_q ? (~acc_hi_q + 32'd1) : acc_hi_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        b_d      = b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;

        case (state_q)
            IDLE: ;
            // One settle cycle after the last iteration keeps latency at 34 edges.
            CALC: begin
                if (cnt_q == ITER_CNT) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (is_div_q) begin
                        acc_hi_d = as_cout ? as_sum[31:0] : as_a[31:0];
                        acc_lo_d = {acc_lo_q[30:0], as_cout};
                    end else begin
                        acc_hi_d = as_sum[32:1];
                        acc_lo_d = {as_sum[0], acc_lo_q[31:1]};
                    end
                end
            end
            // A zero divisor leaves remainder = |dividend|; re-signing restores the dividend.
            FIX: begin
                state_d = DONE;
                if (is_div_q) begin
                    dbz_d = (b_q == 32'd0);
                    hi_d  = rem_fix;
                    lo_d  = (b_q == 32'd0) ? 32'hFFFF_FFFF : quo_fix;
                end else begin
                    dbz_d = 1'b0;
                    hi_d  = prod_fix[63:32];
                    lo_d  = prod_fix[31:0];
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d  = CALC;
            cnt_d    = 6'd0;
            is_div_d = (Op == OP_DIVU) || (Op == OP_DIV);
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            b_d      = b_neg ? abs32(OperandB) : OperandB;
            acc_hi_d = 32'd0;
            acc_lo_d = a_neg ? abs32(OperandA) : OperandA;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            b_q      <= 32'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            b_q      <= b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops against an arithmetic model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] OperandA, OperandB;
    logic        Ready, Busy, Done, DivByZero;
    logic [31:0] Hi, Lo;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] prev_hi = 32'd0;
    logic [31:0] prev_lo = 32'd0;

    always #5 clock = ~clock;

    mult_div_unit dut (
        .clock     (clock),
        .reset     (reset),
        .Start     (Start),
        .Op        (Op),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .Ready     (Ready),
        .Busy      (Busy),
        .Done      (Done),
        .Hi        (Hi),
        .Lo        (Lo),
        .DivByZero (DivByZero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        longint sa, sb, q, r, p;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        dbz = 1'b0;
        case (op)
            2'b00: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
            2'b01: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    dbz = 1'b1; lo = 32'hFFFF_FFFF; hi = a;
                end else if (op == 2'b10) begin
                    lo = a / b; hi = a % b;
                end else begin
                    q = sa / sb; r = sa % sb;
                    lo = q[31:0]; hi = r[31:0];
                end
            end
        endcase
    endtask

    // Counts edges until Done is seen; also watches that Hi/Lo hold and Busy stays up.
    task automatic wait_done(input logic glitch, output int n, output logic bad_hold, output logic bad_busy);
        n = 0; bad_hold = 1'b0; bad_busy = 1'b0;
        while (!Done && n < 100) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (glitch) Start = (n == 10);
            if (!Done && (Hi !== prev_hi || Lo !== prev_lo)) bad_hold = 1'b1;
            if (!Done && !Busy) bad_busy = 1'b1;
        end
        if (glitch) Start = 1'b0;
    endtask

    // Called at a falling edge; returns at a falling edge with the unit back in IDLE.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic glitch);
        logic [31:0] eh, el;
        logic ed, bh, bb;
        int n;
        model(op, a, b, eh, el, ed);
        check({tag, "_ready"}, {63'd0, Ready}, 64'd1);
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        @(posedge clock);
        @(negedge clock);
        Start = 1'b0; Op = 2'($urandom); OperandA = $urandom; OperandB = $urandom;
        wait_done(glitch, n, bh, bb);
        check({tag, "_lat"}, 64'(n), 64'd34);
        check({tag, "_hold"}, {62'd0, bh, bb}, 64'd0);
        check({tag, "_res"}, {Hi, Lo}, {eh, el});
        check({tag, "_dbz"}, {63'd0, DivByZero}, {63'd0, ed});
        prev_hi = eh; prev_lo = el;
        @(posedge clock);
        @(negedge clock);
        check({tag, "_pulse"}, {62'd0, Done, Ready}, 64'd1);
    endtask

    task automatic run_b2b(input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                           input logic [1:0] op2, input logic [31:0] a2, input logic [31:0] b2);
        logic [31:0] eh1, el1, eh2, el2;
        logic ed1, ed2, bh, bb;
        int n;
        model(op1, a1, b1, eh1, el1, ed1);
        model(op2, a2, b2, eh2, el2, ed2);
        Start = 1'b1; Op = op1; OperandA = a1; OperandB = b1;
        @(posedge clock);
        @(negedge clock);
        Op = op2; OperandA = a2; OperandB = b2;
        wait_done(1'b0, n, bh, bb);
        check("b2b_lat1", 64'(n), 64'd34);
        check("b2b_res1", {31'd0, ed1, Hi, Lo}, {31'd0, DivByZero, eh1, el1});
        check("b2b_res1_exp", {Hi, Lo}, {eh1, el1});
        prev_hi = eh1; prev_lo = el1;
        @(posedge clock);
        @(negedge clock);
        Start = 1'b0; OperandA = $urandom; OperandB = $urandom;
        check("b2b_accept", {62'd0, Done, Busy}, 64'd1);
        wait_done(1'b0, n, bh, bb);
        check("b2b_gap", 64'(n + 1), 64'd35);
        check("b2b_res2", {Hi, Lo}, {eh2, el2});
        check("b2b_dbz2", {63'd0, DivByZero}, {63'd0, ed2});
        prev_hi = eh2; prev_lo = el2;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run_reset_abort();
        logic saw_done;
        Start = 1'b1; Op = 2'b00; OperandA = 32'h1234_5678; OperandB = 32'h9ABC_DEF0;
        @(posedge clock);
        @(negedge clock);
        Start = 1'b0;
        repeat (10) begin @(posedge clock); @(negedge clock); end
        reset = 1'b0;
        #1;
        check("rst_mid_hilo", {Hi, Lo}, 64'd0);
        check("rst_mid_flags", {60'd0, Busy, Done, DivByZero, Ready}, 64'd1);
        saw_done = 1'b0;
        repeat (3) begin @(negedge clock); if (Done) saw_done = 1'b1; end
        check("rst_mid_nodone", {63'd0, saw_done}, 64'd0);
        reset = 1'b1;
        prev_hi = 32'd0; prev_lo = 32'd0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; Start = 1'b0; Op = 2'b00; OperandA = 32'd0; OperandB = 32'd0;
        #1;
        check("rst_hilo", {Hi, Lo}, 64'd0);
        check("rst_flags", {60'd0, Busy, Done, DivByZero, Ready}, 64'd1);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_neg", 2'b01, -32'sd7, 32'd3, 1'b0);
        run_op("div_neg", 2'b11, -32'sd7, 32'd2, 1'b0);
        run_op("divu_zero", 2'b10, 32'd100, 32'd0, 1'b0);
        run_op("divu_7", 2'b10, 32'd100, 32'd7, 1'b0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_zero_neg", 2'b11, -32'sd9, 32'd0, 1'b0);
        run_op("glitch", 2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        run_b2b(2'b11, 32'd1000, -32'sd33, 2'b00, 32'hDEAD_BEEF, 32'h0BAD_F00D);

        run_reset_abort();
        run_op("post_rst", 2'b11, 32'd77, -32'sd5, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_op("rand", 2'($urandom), pick(), pick(), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Port list SHALL be, in order:
  clock      in   1   rising-edge clock, shared with register bank
  reset      in   1   asynchronous, active-low reset
  Start      in   1   request; sampled on rising edge when Ready
  Op         in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
  OperandA   in   32  rs value (register bank OutA); multiplicand / dividend
  OperandB   in   32  rt value (register bank OutB); multiplier / divisor
  Ready      out  1   high when a Start will be accepted
  Busy       out  1   high while an operation is in progress
  Done       out  1   one-cycle completion pulse
  Hi         out  32  high product word / remainder
  Lo         out  32  low product word / quotient
  DivByZero  out  1   sticky flag for the last operation

Function
REQ-003 The FSM SHALL have states IDLE, CALC, FIX, DONE.
REQ-004 Ready SHALL be 1 in IDLE and DONE, and 0 otherwise; Busy SHALL be 1 in CALC and FIX only.
REQ-005 On a rising edge with Start=1 and Ready=1, the block SHALL latch Op, OperandA and OperandB, clear the iteration counter, and enter CALC; Start with Ready=0 SHALL be ignored.
REQ-006 Input operands SHALL be latched; later changes to OperandA/OperandB SHALL NOT affect the result.
REQ-007 For signed ops, the block SHALL convert operands to magnitudes at the latch and record the result signs.
REQ-008 CALC SHALL perform exactly 32 iterations, one per cycle: shift-add for multiply, restoring shift-subtract for divide, using a 33-bit add/sub datapath.
REQ-009 After the 32nd iteration, the FSM SHALL enter FIX; FIX SHALL apply sign correction and register Hi/Lo.
REQ-010 From FIX the FSM SHALL enter DONE, where Done=1 for exactly one cycle.
REQ-011 Latency SHALL be fixed: Done is high during the cycle following the 34th rising edge after the Start-sampling edge, for every Op and operand value.
REQ-012 Hi/Lo SHALL change only on the FIX-to-DONE edge and SHALL hold until the next completion.
REQ-013 MULT/MULTU SHALL produce Hi:Lo = the 64-bit product; MULT is two's-complement.
REQ-014 DIV/DIVU SHALL produce Lo = quotient and Hi = remainder; for DIV, the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-015 For a divisor of 0, the block SHALL still take full latency, set DivByZero=1, and produce Lo=32'hFFFFFFFF and Hi=dividend (as presented).
REQ-016 DIV with 32'h80000000 / 32'hFFFFFFFF SHALL produce Lo=32'h80000000 and Hi=0, with DivByZero=0.
REQ-017 DivByZero SHALL update at the FIX-to-DONE edge and SHALL hold until the next completion.
REQ-018 In DONE with Start=1, the new operation SHALL be accepted (back-to-back) and the FSM SHALL go to CALC; with Start=0, the FSM SHALL return to IDLE.

Reset
REQ-019 When reset=0, the block SHALL asynchronously force state IDLE, Hi=0, Lo=0, Done=0, DivByZero=0, and clear the counter and all internal operand registers.
REQ-020 Reset mid-operation SHALL abort the operation with no Done pulse.
REQ-021 The first Start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-022 Op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV), state encodings and the 32-iteration count constant SHALL live in the shared CPU package.
REQ-023 One sub-module, muldiv_addsub (33-bit add/subtract with carry/borrow out), SHALL implement the iteration datapath.

Verification
REQ-024 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> Done after 34 edges; Hi=32'hFFFFFFFE, Lo=32'h00000001.
REQ-025 MULT -7 x 3 -> Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB; DIV -7 / 2 -> Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF.
REQ-026 DIVU 100 / 0 -> DivByZero=1, Lo=32'hFFFFFFFF, Hi=100; then DIVU 100 / 7 -> DivByZero=0, Lo=14, Hi=2.
REQ-027 Back-to-back: Start held high across DONE -> second Done exactly 35 edges after the first; Start pulsed while Busy -> ignored, Hi/Lo unchanged.
REQ-028 reset=0 asserted at iteration 10 -> Hi=Lo=0 and Busy=0 immediately, with no Done pulse; a fresh Start after release completes correctly.
REQ-029 DIV 32'h80000000 / 32'hFFFFFFFF -> Lo=32'h80000000, Hi=0, DivByZero=0.
